branch_predict_ctrl: RTL and testbench

- Direction predictor and misprediction controller for the RV32IM 5-stage pipeline.
- Holds a branch history table (BHT) of 2-bit saturating counters indexed by PC.
- Supplies a taken/not-taken prediction to IF and evaluates the real outcome in EX from the ALU ZERO/NOTZERO flags.
- On a misprediction it sequences the redirect and flush of IF/ID and ID/EX. It also keeps branch and mispredict statistics.

---
 rtl/branch_pkg.sv | 51 +++++
 rtl/bht_table.sv | 32 +++
 rtl/branch_predict_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch direction predictor:
// branch-type codes, BHT counter encodings, controller states.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_Z_A   = 3'd1,
    BR_NZ_A  = 3'd2,
    BR_Z_B   = 3'd3,
    BR_NZ_B  = 3'd4,
    BR_Z_C   = 3'd5,
    BR_NZ_C  = 3'd6,
    BR_JUMP  = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [1:0] sat_update(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] r;
    r = ctr;
    if (taken && ctr != ST)
      r = ctr + 2'd1;
    else if (!taken && ctr != SNT)
      r = ctr - 2'd1;
    return r;
  endfunction

  // Odd codes other than the jump test ZERO, even non-zero codes test NOTZERO.
  function automatic logic is_zero_type(input logic [2:0] t);
    return t[0] && (t != BR_JUMP);
  endfunction

  function automatic logic is_nz_type(input logic [2:0] t);
    return !t[0] && (t != BR_NONE);
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2-bit counters, async read for fetch,
// synchronous write doing either an init store or a saturating update.
module bht_table
  import branch_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic                  wr_init,
  input  logic                  wr_taken,
  input  logic [INDEX_BITS-1:0] wr_idx
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic [1:0] mem [DEPTH];

  assign rd_ctr = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_init)
        mem[wr_idx] <= WNT;
      else
        mem[wr_idx] <= sat_update(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direction predictor plus misprediction redirect/flush sequencer
// with branch and mispredict statistics.
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IF_VALID,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PRED_TAKEN,
  input  logic            EX_VALID,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [2:0]      EX_BRANCH_TYPE,
  input  logic            ZERO,
  input  logic            NOTZERO,
  input  logic            EX_PRED_TAKEN,
  input  logic [XLEN-1:0] EX_TARGET,
  input  logic            CLR_STATS,
  output logic            INIT_BUSY,
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic            FLUSH_IFID,
  output logic            FLUSH_IDEX,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISPRED_COUNT
);

  state_e                state;
  state_e                state_nx;
  logic [INDEX_BITS-1:0] init_idx;
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [1:0]            if_ctr;
  logic                  actual;
  logic                  resolve;
  logic                  upd;
  logic                  mispred;
  logic                  wr_en;
  logic                  wr_init;
  logic [INDEX_BITS-1:0] wr_idx;
  logic                  unused_pc_bits;

  assign if_idx = IF_PC[INDEX_BITS+1:2];
  assign ex_idx = EX_PC[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{IF_PC[XLEN-1:INDEX_BITS+2], IF_PC[1:0]};

  always_comb begin
    actual = 1'b0;
    unique case (1'b1)
      (EX_BRANCH_TYPE == BR_JUMP):  actual = 1'b1;
      is_zero_type(EX_BRANCH_TYPE): actual = ZERO;
      is_nz_type(EX_BRANCH_TYPE):   actual = NOTZERO;
      default:                      actual = 1'b0;
    endcase
  end

  assign resolve = (state == READY) && EX_VALID &&
                   (EX_BRANCH_TYPE != BR_NONE);
  assign upd     = resolve && (EX_BRANCH_TYPE != BR_JUMP);
  assign mispred = resolve && (actual != EX_PRED_TAKEN);

  assign wr_init = (state == INIT);
  assign wr_en   = wr_init || upd;
  assign wr_idx  = wr_init ? init_idx : ex_idx;

  bht_table #(
    .INDEX_BITS(INDEX_BITS)
  ) u_bht (
    .clk      (CLK),
    .rd_idx   (if_idx),
    .rd_ctr   (if_ctr),
    .wr_en    (wr_en),
    .wr_init  (wr_init),
    .wr_taken (actual),
    .wr_idx   (wr_idx)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT)
        init_idx <= init_idx + INDEX_BITS'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (init_idx == '1) state_nx = READY;
      READY:   if (mispred) state_nx = FLUSH;
      FLUSH:   state_nx = READY;
      default: state_nx = INIT;
    endcase
  end

  // The FLUSH state is exactly the one-cycle redirect window.
  assign INIT_BUSY  = (state == INIT);
  assign REDIRECT   = (state == FLUSH);
  assign FLUSH_IFID = (state == FLUSH);
  assign FLUSH_IDEX = (state == FLUSH);
  assign PRED_TAKEN = (state == READY) && IF_VALID && if_ctr[1];

  always_ff @(posedge CLK) begin
    if (RESET)
      REDIRECT_PC <= '0;
    else if (mispred)
      REDIRECT_PC <= actual ? EX_TARGET : EX_PC + XLEN'(4);
  end

  always_ff @(posedge CLK) begin
    if (RESET || CLR_STATS) begin
      BR_COUNT      <= '0;
      MISPRED_COUNT <= '0;
    end else begin
      if (resolve && BR_COUNT != '1)
        BR_COUNT <= BR_COUNT + 32'd1;
      if (mispred && MISPRED_COUNT != '1)
        MISPRED_COUNT <= MISPRED_COUNT + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios plus random
// traffic checked against a behavioural predictor model.
module tb_branch_predict_ctrl;

  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic        PRED_TAKEN;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic [2:0]  EX_BRANCH_TYPE;
  logic        ZERO;
  logic        NOTZERO;
  logic        EX_PRED_TAKEN;
  logic [31:0] EX_TARGET;
  logic        CLR_STATS;
  logic        INIT_BUSY;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        FLUSH_IFID;
  logic        FLUSH_IDEX;
  logic [31:0] BR_COUNT;
  logic [31:0] MISPRED_COUNT;

  always #5 CLK = ~CLK;

  branch_predict_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .IF_VALID(IF_VALID), .IF_PC(IF_PC), .PRED_TAKEN(PRED_TAKEN),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC),
    .EX_BRANCH_TYPE(EX_BRANCH_TYPE), .ZERO(ZERO), .NOTZERO(NOTZERO),
    .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_TARGET(EX_TARGET),
    .CLR_STATS(CLR_STATS), .INIT_BUSY(INIT_BUSY),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX),
    .BR_COUNT(BR_COUNT), .MISPRED_COUNT(MISPRED_COUNT)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_bht [DEPTH];
  int          m_init_left;
  bit          m_redir;
  logic [31:0] m_rpc;
  longint      m_br;
  longint      m_mis;
  bit          m_ok = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[idx_of(pc)] >= 2;
  endfunction

  task automatic model_step();
    bit act;
    int i;
    if (RESET) begin
      m_init_left = DEPTH;
      m_redir = 0;
      m_rpc = 0;
      m_br = 0;
      m_mis = 0;
      m_ok = 1;
    end else begin
      if (m_init_left > 0) begin
        m_bht[DEPTH - m_init_left] = 1;
        m_init_left--;
      end else if (m_redir) begin
        m_redir = 0;
      end else if (EX_VALID && EX_BRANCH_TYPE != 0) begin
        if (EX_BRANCH_TYPE == 7) act = 1;
        else if (EX_BRANCH_TYPE % 2 == 1) act = ZERO;
        else act = NOTZERO;
        i = idx_of(EX_PC);
        if (EX_BRANCH_TYPE != 7)
          m_bht[i] = act ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                         : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (act != EX_PRED_TAKEN) begin
          if (m_mis < 64'hFFFF_FFFF) m_mis++;
          m_redir = 1;
          m_rpc = act ? EX_TARGET : EX_PC + 32'd4;
        end
      end
      if (CLR_STATS) begin
        m_br = 0;
        m_mis = 0;
      end
    end
  endtask

  // Inputs are already driven; check prediction, clock, check state.
  task automatic tick();
    bit exp_p;
    if (m_ok && !RESET) begin
      #1;
      exp_p = (m_init_left == 0) && !m_redir && IF_VALID && m_pred(IF_PC);
      chk("pred", {31'd0, PRED_TAKEN}, {31'd0, exp_p});
    end
    @(posedge CLK);
    model_step();
    #1;
    chk("init_busy", {31'd0, INIT_BUSY}, {31'd0, m_init_left > 0});
    chk("redirect", {31'd0, REDIRECT}, {31'd0, m_redir});
    chk("flush_ifid", {31'd0, FLUSH_IFID}, {31'd0, m_redir});
    chk("flush_idex", {31'd0, FLUSH_IDEX}, {31'd0, m_redir});
    chk("redirect_pc", REDIRECT_PC, m_rpc);
    chk("br_count", BR_COUNT, m_br[31:0]);
    chk("mispred_count", MISPRED_COUNT, m_mis[31:0]);
  endtask

  task automatic ex_set(input logic v, input logic [31:0] pc,
                        input logic [2:0] t, input logic z,
                        input logic nz, input logic pt,
                        input logic [31:0] tgt);
    EX_VALID = v;
    EX_PC = pc;
    EX_BRANCH_TYPE = t;
    ZERO = z;
    NOTZERO = nz;
    EX_PRED_TAKEN = pt;
    EX_TARGET = tgt;
  endtask

  task automatic idle();
    ex_set(0, 0, 0, 0, 0, 0, 0);
    CLR_STATS = 0;
  endtask

  task automatic do_reset();
    RESET = 1;
    tick();
    RESET = 0;
    for (int k = 0; k < DEPTH; k++) begin
      chk("init_busy_window", {31'd0, INIT_BUSY}, 32'd1);
      tick();
    end
    chk("init_done", {31'd0, INIT_BUSY}, 32'd0);
  endtask

  initial begin
    RESET = 1;
    IF_VALID = 0;
    IF_PC = 0;
    idle();
    #2;
    do_reset();
    chk("br_reset", BR_COUNT, 32'd0);
    chk("mis_reset", MISPRED_COUNT, 32'd0);

    // Every entry starts weakly not-taken
    IF_VALID = 1;
    for (int k = 0; k < DEPTH; k++) begin
      IF_PC = 32'(k * 4);
      tick();
    end

    // Mispredicted taken branch
    IF_PC = 32'h100;
    ex_set(1, 32'h100, 3'd1, 1, 0, 0, 32'h200);
    tick();
    chk("redir_pulse", {31'd0, REDIRECT}, 32'd1);
    chk("redir_target", REDIRECT_PC, 32'h200);
    chk("br1", BR_COUNT, 32'd1);
    chk("mis1", MISPRED_COUNT, 32'd1);
    idle();
    tick();
    chk("redir_drop", {31'd0, REDIRECT}, 32'd0);
    #1;
    chk("pred_0x100", {31'd0, PRED_TAKEN}, 32'd1);
    tick();

    // Fall-through wraps around the address space
    ex_set(1, 32'hFFFF_FFFC, 3'd2, 0, 0, 1, 32'h40);
    tick();
    chk("wrap_pc", REDIRECT_PC, 32'h0);
    // Resolve offered during FLUSH is ignored
    ex_set(1, 32'h100, 3'd1, 1, 0, 0, 32'h300);
    tick();
    chk("flush_ignore_br", BR_COUNT, 32'd2);
    idle();
    tick();
    chk("no_second_redir", {31'd0, REDIRECT}, 32'd0);

    // Saturate one entry at ST, then one not-taken leaves it taken
    IF_PC = 32'h80;
    for (int k = 0; k < 4; k++) begin
      ex_set(1, 32'h80, 3'd3, 1, 0, m_pred(32'h80), 32'h500);
      tick();
      idle();
      tick();
    end
    ex_set(1, 32'h80, 3'd5, 0, 1, 1, 32'h500);
    tick();
    idle();
    tick();
    #1;
    chk("pred_after_st_wt", {31'd0, PRED_TAKEN}, 32'd1);
    tick();

    // Unconditional jump mispredicted: redirect, BHT untouched
    IF_PC = 32'h0C;
    ex_set(1, 32'h0C, 3'd7, 0, 0, 0, 32'h1234);
    tick();
    chk("jump_target", REDIRECT_PC, 32'h1234);
    idle();
    tick();
    #1;
    chk("jump_no_bht", {31'd0, PRED_TAKEN}, 32'd0);
    tick();

    // Clear wins over a same-cycle increment
    ex_set(1, 32'h20, 3'd4, 0, 1, 0, 32'h60);
    CLR_STATS = 1;
    tick();
    chk("clr_br", BR_COUNT, 32'd0);
    chk("clr_mis", MISPRED_COUNT, 32'd0);
    idle();
    tick();

    // Reset during FLUSH
    ex_set(1, 32'h24, 3'd6, 0, 0, 1, 32'h70);
    tick();
    idle();
    RESET = 1;
    tick();
    chk("rst_flush_redir", {31'd0, REDIRECT}, 32'd0);
    chk("rst_flush_busy", {31'd0, INIT_BUSY}, 32'd1);
    RESET = 0;
    for (int k = 0; k < DEPTH; k++) tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      IF_VALID = 1'($urandom);
      IF_PC = {22'd0, 8'($urandom), 2'b00};
      ex_set(1'($urandom), pc, 3'($urandom), 1'($urandom),
             1'($urandom), 1'b0, $urandom & 32'hFFFF_FFFC);
      EX_PRED_TAKEN = ($urandom_range(0, 3) == 0) ? 1'($urandom)
                                                 : m_pred(pc);
      CLR_STATS = ($urandom_range(0, 99) == 0);
      RESET = ($urandom_range(0, 799) == 0);
      tick();
    end
    RESET = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
